// File: rtl/ps2_scancode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_sequencer
// Description : Turns the raw PS/2 Set-2 byte stream from PS2_Controller into
//               one event per completed make/break code. It tracks the E0
//               (extended) and F0 (break) prefixes and keeps held/press state
//               for the Enter, Left and Right game keys.
// Ports       : CLOCK_50            system clock, posedge
//               resetn              asynchronous active-low reset
//               flush               synchronous clear of FSM and held flags
//               rx_data/rx_valid    byte stream from PS2_Controller
//               code_valid          one-cycle pulse per decoded code
//               code_byte/ext/break last decoded code, held until the next one
//               *_held              key currently down
//               *_press             one-cycle pulse on a 0->1 held transition
//               seq_err             one-cycle pulse on an aborted prefix sequence
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_sequencer #(
  parameter logic [7:0] KEY_ENTER      = 8'h5A,
  parameter logic [7:0] KEY_LEFT       = 8'h6B,
  parameter logic [7:0] KEY_RIGHT      = 8'h74,
  parameter bit         ARROW_EXT_ONLY = 1'b1,
  parameter int         TIMEOUT_CYC    = 50000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       flush,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       code_valid,
  output logic [7:0] code_byte,
  output logic       code_ext,
  output logic       code_break,
  output logic       enter_held,
  output logic       left_held,
  output logic       right_held,
  output logic       enter_press,
  output logic       left_press,
  output logic       right_press,
  output logic       seq_err
);

  localparam int             c_CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYC);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_EXT     = 2'd1;
  localparam logic [1:0] c_BRK     = 2'd2;
  localparam logic [1:0] c_EXT_BRK = 2'd3;

  localparam logic [7:0] c_PFX_EXT = 8'hE0;
  localparam logic [7:0] c_PFX_BRK = 8'hF0;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [c_CNT_W-1:0] w_cnt_inc;
  logic               w_emit;
  logic               w_ext;
  logic               w_brk;
  logic               w_err;
  logic               w_ignore;
  logic               w_is_pfx;

  // Keyboard housekeeping bytes (BAT, ACK, resend, echo, error) that carry no key.
  assign w_ignore = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
                    (rx_data == 8'hEE) || (rx_data == 8'h00) || (rx_data == 8'hFF);
  assign w_is_pfx = (rx_data == c_PFX_EXT) || (rx_data == c_PFX_BRK);
  assign w_cnt_inc = r_cnt + 1'b1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic, including the prefix timeout
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_ext       = 1'b0;
    w_brk       = 1'b0;
    w_err       = 1'b0;
    if (flush) begin
      w_state_nxt = c_IDLE;
      w_cnt_nxt   = '0;
    end else if (rx_valid) begin
      // A byte arriving on the expiry cycle wins over the timeout.
      w_cnt_nxt = '0;
      case (r_state)
        c_IDLE: begin
          if (rx_data == c_PFX_EXT)      w_state_nxt = c_EXT;
          else if (rx_data == c_PFX_BRK) w_state_nxt = c_BRK;
          else if (!w_ignore)            w_emit      = 1'b1;
        end
        c_EXT: begin
          if (rx_data == c_PFX_BRK)      w_state_nxt = c_EXT_BRK;
          else if (rx_data == c_PFX_EXT) w_state_nxt = c_EXT;
          else begin
            w_state_nxt = c_IDLE;
            w_emit      = 1'b1;
            w_ext       = 1'b1;
          end
        end
        c_BRK: begin
          w_state_nxt = c_IDLE;
          if (w_is_pfx) w_err = 1'b1;
          else begin
            w_emit = 1'b1;
            w_brk  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = c_IDLE;
          if (w_is_pfx) w_err = 1'b1;
          else begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
            w_brk  = 1'b1;
          end
        end
      endcase
    end else if (r_state != c_IDLE) begin
      if (w_cnt_inc == c_TIMEOUT) begin
        w_state_nxt = c_IDLE;
        w_cnt_nxt   = '0;
        w_err       = 1'b1;
      end else begin
        w_cnt_nxt = w_cnt_inc;
      end
    end else begin
      w_cnt_nxt = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: key matching and held/press updates
  // --------------------------------------------------------------------------
  logic w_arrow_ok;
  logic w_hit_enter, w_hit_left, w_hit_right;
  logic w_enter_held_nxt, w_left_held_nxt, w_right_held_nxt;
  logic w_enter_press_nxt, w_left_press_nxt, w_right_press_nxt;

  assign w_arrow_ok  = w_ext || !ARROW_EXT_ONLY;
  assign w_hit_enter = w_emit && (rx_data == KEY_ENTER);
  assign w_hit_left  = w_emit && w_arrow_ok && (rx_data == KEY_LEFT);
  assign w_hit_right = w_emit && w_arrow_ok && (rx_data == KEY_RIGHT);

  always_comb begin
    w_enter_held_nxt  = enter_held;
    w_left_held_nxt   = left_held;
    w_right_held_nxt  = right_held;
    // Press only on a make that finds the key up; typematic repeats are silent.
    w_enter_press_nxt = w_hit_enter && !w_brk && !enter_held;
    w_left_press_nxt  = w_hit_left  && !w_brk && !left_held;
    w_right_press_nxt = w_hit_right && !w_brk && !right_held;
    if (w_hit_enter) w_enter_held_nxt = !w_brk;
    if (w_hit_left)  w_left_held_nxt  = !w_brk;
    if (w_hit_right) w_right_held_nxt = !w_brk;
    if (flush) begin
      w_enter_held_nxt = 1'b0;
      w_left_held_nxt  = 1'b0;
      w_right_held_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      code_valid  <= 1'b0;
      code_byte   <= 8'h00;
      code_ext    <= 1'b0;
      code_break  <= 1'b0;
      enter_held  <= 1'b0;
      left_held   <= 1'b0;
      right_held  <= 1'b0;
      enter_press <= 1'b0;
      left_press  <= 1'b0;
      right_press <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      code_valid  <= w_emit;
      if (w_emit) begin
        code_byte  <= rx_data;
        code_ext   <= w_ext;
        code_break <= w_brk;
      end
      enter_held  <= w_enter_held_nxt;
      left_held   <= w_left_held_nxt;
      right_held  <= w_right_held_nxt;
      enter_press <= w_enter_press_nxt;
      left_press  <= w_left_press_nxt;
      right_press <= w_right_press_nxt;
      seq_err     <= w_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_scancode_sequencer
// Description : Scoreboard bench for ps2_scancode_sequencer. Stimulus pushes
//               hand-computed expected events; a monitor pops them whenever the
//               DUT pulses code_valid or seq_err. A second instance with
//               ARROW_EXT_ONLY=0 shares the inputs for the keypad-arrow case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scancode_sequencer;

  localparam int c_TO = 40;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       flush    = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;

  logic       code_valid, code_ext, code_break, seq_err;
  logic [7:0] code_byte;
  logic       enter_held, left_held, right_held, enter_press, left_press, right_press;

  logic       d0_code_valid, d0_code_ext, d0_code_break, d0_seq_err;
  logic [7:0] d0_code_byte;
  logic       d0_enter_held, d0_left_held, d0_right_held;
  logic       d0_enter_press, d0_left_press, d0_right_press;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_scancode_sequencer #(.ARROW_EXT_ONLY(1'b1), .TIMEOUT_CYC(c_TO)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .flush(flush),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .code_valid(code_valid), .code_byte(code_byte), .code_ext(code_ext),
    .code_break(code_break), .enter_held(enter_held), .left_held(left_held),
    .right_held(right_held), .enter_press(enter_press), .left_press(left_press),
    .right_press(right_press), .seq_err(seq_err)
  );

  ps2_scancode_sequencer #(.ARROW_EXT_ONLY(1'b0), .TIMEOUT_CYC(c_TO)) dut0 (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .flush(flush),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .code_valid(d0_code_valid), .code_byte(d0_code_byte), .code_ext(d0_code_ext),
    .code_break(d0_code_break), .enter_held(d0_enter_held), .left_held(d0_left_held),
    .right_held(d0_right_held), .enter_press(d0_enter_press), .left_press(d0_left_press),
    .right_press(d0_right_press), .seq_err(d0_seq_err)
  );

  // kind 0 = code event, kind 1 = seq_err event
  typedef struct packed {
    logic       kind;
    logic [7:0] b;
    logic       ext, brk, eh, lh, rh, ep, lp, rp;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop one expectation per DUT event.
  always @(negedge CLOCK_50) begin
    if (code_valid || seq_err) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {code_valid, seq_err, code_byte}, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.kind) begin
          chk("seq_err_event", {code_valid, seq_err}, 32'h1);
        end else begin
          chk("code_event",
              {code_valid, seq_err, code_byte, code_ext, code_break, enter_held, left_held,
               right_held, enter_press, left_press, right_press},
              {1'b1, 1'b0, e.b, e.ext, e.brk, e.eh, e.lh, e.rh, e.ep, e.lp, e.rp});
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic fl = 1'b0);
    @(negedge CLOCK_50);
    rx_data  = b;
    rx_valid = 1'b1;
    flush    = fl;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic push_code(input logic [7:0] b, input logic ext, brk, eh, lh, rh, ep, lp, rp);
    exp_t e;
    e = '{kind: 1'b0, b: b, ext: ext, brk: brk, eh: eh, lh: lh, rh: rh, ep: ep, lp: lp, rp: rp};
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e = '0;
    e.kind = 1'b1;
    q.push_back(e);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk(nm, q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge CLOCK_50);
    chk("reset_state",
        {code_valid, code_byte, code_ext, code_break, enter_held, left_held, right_held,
         enter_press, left_press, right_press, seq_err}, 32'h0);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // 1: Enter make then break
    push_code(8'h5A, 0, 0, 1, 0, 0, 1, 0, 0); send(8'h5A);
    send(8'hAA);                                   // housekeeping byte, no event
    push_code(8'h5A, 0, 1, 0, 0, 0, 0, 0, 0); send(8'hF0); send(8'h5A);
    // keypad Enter (E0 5A) also counts
    push_code(8'h5A, 1, 0, 1, 0, 0, 1, 0, 0); send(8'hE0); send(8'h5A);
    push_code(8'h5A, 1, 1, 0, 0, 0, 0, 0, 0); send(8'hE0); send(8'hF0); send(8'h5A);

    // 2: Left typematic repeats, single press, then release
    push_code(8'h6B, 1, 0, 0, 1, 0, 0, 1, 0); send(8'hE0); send(8'h6B);
    push_code(8'h6B, 1, 0, 0, 1, 0, 0, 0, 0); send(8'hE0); send(8'h6B);
    push_code(8'h6B, 1, 0, 0, 1, 0, 0, 0, 0); send(8'hE0); send(8'hE0); send(8'h6B);
    push_code(8'h6B, 1, 1, 0, 0, 0, 0, 0, 0); send(8'hE0); send(8'hF0); send(8'h6B);
    drain("drain_t2");
    chk("left_held_after_break", left_held, 0);

    // 3: keypad 4 without E0
    push_code(8'h6B, 0, 0, 0, 0, 0, 0, 0, 0); send(8'h6B);
    chk("kp_left_ext_only", left_held, 0);
    chk("kp_left_any", d0_left_held, 1);
    push_code(8'h6B, 0, 1, 0, 0, 0, 0, 0, 0); send(8'hF0); send(8'h6B);
    chk("kp_left_any_release", d0_left_held, 0);

    // 4: break prefix timeout
    push_err();
    send(8'hF0);
    n = 0;
    while (!seq_err && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("timeout_cycles", n, c_TO);
    push_code(8'h74, 0, 0, 0, 0, 0, 0, 0, 0); send(8'h74);
    drain("drain_t4");

    // 5: illegal prefix pair, then flush clears Right and drops the byte
    push_err(); send(8'hF0); send(8'hE0);
    push_code(8'h74, 1, 0, 0, 0, 1, 0, 0, 1); send(8'hE0); send(8'h74);
    send(8'hE0); send(8'h74, 1'b1);
    @(negedge CLOCK_50);
    chk("flush_right_held", right_held, 0);
    chk("flush_no_event", {code_valid, seq_err}, 0);
    drain("drain_t5");

    // 6: Right and Left together, then reset mid E0 F0
    push_code(8'h74, 1, 0, 0, 0, 1, 0, 0, 1); send(8'hE0); send(8'h74);
    push_code(8'h6B, 1, 0, 0, 1, 1, 0, 1, 0); send(8'hE0); send(8'h6B);
    chk("both_held", {left_held, right_held}, 2'b11);
    send(8'hE0); send(8'hF0);
    resetn = 1'b0;
    #1;
    chk("mid_seq_reset",
        {code_valid, code_byte, code_ext, code_break, enter_held, left_held, right_held,
         enter_press, left_press, right_press, seq_err}, 32'h0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    push_code(8'h74, 0, 0, 0, 0, 0, 0, 0, 0); send(8'h74);
    drain("drain_t6");

    repeat (3) @(negedge CLOCK_50);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
